// File: rtl/quad_pkg.sv
// Shared phase encoding and step classification for the quadrature decoder.
package quad_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_t;

  function automatic phase_t next_fwd(input phase_t p);
    case (p)
      PH_00:   next_fwd = PH_01;
      PH_01:   next_fwd = PH_11;
      PH_11:   next_fwd = PH_10;
      default: next_fwd = PH_00;
    endcase
  endfunction

  // Any change that is neither a forward nor a reverse neighbour flips both bits.
  function automatic step_t classify(input phase_t prev, input phase_t cur);
    if (cur == prev)                classify = STEP_NONE;
    else if (cur == next_fwd(prev)) classify = STEP_FWD;
    else if (prev == next_fwd(cur)) classify = STEP_REV;
    else                            classify = STEP_ERR;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: two-flop synchroniser followed by a debounce counter.
module quad_filter #(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  input  logic load,
  output logic filt_out
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      logic unused_load;
      assign unused_load = load;
      assign filt_out    = sync2;
    end else begin : g_filter
      localparam int CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

      logic [CNT_W-1:0] cnt;
      logic             filt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt  <= '0;
          filt <= 1'b0;
        end else if (load) begin
          cnt  <= '0;
          filt <= sync2;
        end else if (sync2 != filt) begin
          if (cnt == CNT_LAST) begin
            cnt  <= '0;
            filt <= sync2;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end

      // During priming the decoder captures the value being loaded, not the stale one.
      assign filt_out = load ? sync2 : filt;
    end
  endgenerate

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filters A/B and turns phase steps into one-cycle strobes.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_in,
  input  logic b_in,
  output logic increment,
  output logic decrement,
  output logic error,
  output logic dir
);

  logic [1:0] startup_cnt;
  logic       primed;
  logic       load;
  logic       filt_a;
  logic       filt_b;
  phase_t     cur;
  phase_t     prev;

  assign load = !primed && (startup_cnt == 2'd2);
  assign cur  = {filt_a, filt_b};

  quad_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_in   (a_in),
    .load     (load),
    .filt_out (filt_a)
  );

  quad_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_in   (b_in),
    .load     (load),
    .filt_out (filt_b)
  );

  // Startup priming then registered decode; strobes default low every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      startup_cnt <= 2'd0;
      primed      <= 1'b0;
      prev        <= PH_00;
      increment   <= 1'b0;
      decrement   <= 1'b0;
      error       <= 1'b0;
      dir         <= DIR_UP;
    end else begin
      increment <= 1'b0;
      decrement <= 1'b0;
      error     <= 1'b0;
      if (!primed) begin
        if (load) begin
          primed <= 1'b1;
          prev   <= cur;
        end else begin
          startup_cnt <= startup_cnt + 2'd1;
        end
      end else begin
        prev <= cur;
        case (classify(prev, cur))
          STEP_FWD: begin
            increment <= 1'b1;
            dir       <= DIR_UP;
          end
          STEP_REV: begin
            decrement <= 1'b1;
            dir       <= DIR_DOWN;
          end
          STEP_ERR: error <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench: a filtered (4-cycle) and a bypassed decoder share the same encoder inputs.
module tb_quad_decoder;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } sb_entry_t;

  logic clk = 1'b0;
  logic reset_n;
  logic a_in = 1'b1;
  logic b_in = 1'b1;

  logic increment4, decrement4, error4, dir4;
  logic increment0, decrement0, error0, dir0;

  int        cyc = 0;
  int        total = 0;
  int        bad = 0;
  int        inc_total4 = 0;
  sb_entry_t sb4[$];
  sb_entry_t sb0[$];
  logic [1:0] ph4;
  logic       exp_dir4;
  logic       exp_dir0;

  quad_decoder #(.FILTER_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .increment (increment4),
    .decrement (decrement4),
    .error     (error4),
    .dir       (dir4)
  );

  quad_decoder #(.FILTER_CYCLES(0)) dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .increment (increment0),
    .decrement (decrement0),
    .error     (error0),
    .dir       (dir0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Gray-to-binary ring position; difference mod 4 gives the expected strobe {inc,dec,err}.
  function automatic logic [2:0] expKind(input logic [1:0] o, input logic [1:0] n);
    logic [1:0] po, pn, d;
    po = {o[1], o[1] ^ o[0]};
    pn = {n[1], n[1] ^ n[0]};
    d  = pn - po;
    case (d)
      2'd0:    expKind = 3'b000;
      2'd1:    expKind = 3'b100;
      2'd3:    expKind = 3'b010;
      default: expKind = 3'b001;
    endcase
  endfunction

  // Called at a falling edge; new levels are first sampled by the next rising edge.
  task automatic applyStimulus(input logic na, input logic nb, input int hold, input bit seen4);
    logic [2:0] k;
    k = expKind({a_in, b_in}, {na, nb});
    if (k != 3'b000) sb0.push_back('{cyc + 3, k});
    if (k == 3'b100) exp_dir0 = 1'b1;
    if (k == 3'b010) exp_dir0 = 1'b0;
    if (seen4) begin
      k = expKind(ph4, {na, nb});
      if (k != 3'b000) sb4.push_back('{cyc + 7, k});
      if (k == 3'b100) exp_dir4 = 1'b1;
      if (k == 3'b010) exp_dir4 = 1'b0;
      ph4 = {na, nb};
    end
    a_in = na;
    b_in = nb;
    repeat (hold) @(negedge clk);
    if (hold >= 8) begin
      checkOutput("dir4", dir4, exp_dir4);
      checkOutput("dir0", dir0, exp_dir0);
    end
  endtask

  always @(negedge clk) begin
    sb_entry_t  e;
    logic [2:0] obs;
    obs = {increment4, decrement4, error4};
    if (increment4) inc_total4++;
    if (obs != 3'b000) begin
      if (sb4.size() == 0) checkOutput("spurious4", obs, 3'b000);
      else begin
        e = sb4.pop_front();
        checkOutput("edge4", cyc, e.cyc);
        checkOutput("kind4", obs, e.kind);
      end
    end else if (sb4.size() > 0 && sb4[0].cyc < cyc) begin
      e = sb4.pop_front();
      checkOutput("missed4", obs, e.kind);
    end
  end

  always @(negedge clk) begin
    sb_entry_t  e;
    logic [2:0] obs;
    obs = {increment0, decrement0, error0};
    if (obs != 3'b000) begin
      if (sb0.size() == 0) checkOutput("spurious0", obs, 3'b000);
      else begin
        e = sb0.pop_front();
        checkOutput("edge0", cyc, e.cyc);
        checkOutput("kind0", obs, e.kind);
      end
    end else if (sb0.size() > 0 && sb0[0].cyc < cyc) begin
      e = sb0.pop_front();
      checkOutput("missed0", obs, e.kind);
    end
  end

  initial begin
    logic [1:0] fwd_seq [4];
    logic [3:0] wrap_cnt;
    int         inc_base;
    bit         seen;
    fwd_seq  = '{2'b00, 2'b01, 2'b11, 2'b10};
    exp_dir4 = 1'b1;
    exp_dir0 = 1'b1;
    ph4      = 2'b11;

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_inc", increment4, 1'b0);
    checkOutput("rst_dec", decrement4, 1'b0);
    checkOutput("rst_err", error4, 1'b0);
    checkOutput("rst_dir", dir4, 1'b1);
    checkOutput("rst_dir0", dir0, 1'b1);

    // Inputs held at 11 through release: priming must not produce a pulse.
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    applyStimulus(1'b1, 1'b0, 10, 1'b1);
    applyStimulus(1'b0, 1'b0, 10, 1'b1);

    for (int i = 1; i <= 4; i++)
      applyStimulus(fwd_seq[i % 4][1], fwd_seq[i % 4][0], 10, 1'b1);
    for (int i = 3; i >= 0; i--)
      applyStimulus(fwd_seq[i][1], fwd_seq[i][0], 10, 1'b1);

    applyStimulus(1'b0, 1'b1, 3, 1'b0);
    applyStimulus(1'b0, 1'b0, 10, 1'b1);
    checkOutput("glitch_filt_b", dut.u_filter_b.filt_out, 1'b0);
    applyStimulus(1'b0, 1'b1, 10, 1'b1);
    applyStimulus(1'b0, 1'b0, 10, 1'b1);

    applyStimulus(1'b1, 1'b1, 10, 1'b1);
    applyStimulus(1'b1, 1'b0, 10, 1'b1);
    applyStimulus(1'b0, 1'b0, 10, 1'b1);

    inc_base = inc_total4;
    for (int i = 0; i < 17; i++)
      applyStimulus(fwd_seq[(i + 1) % 4][1], fwd_seq[(i + 1) % 4][0], 8, 1'b1);
    wrap_cnt = 4'(inc_total4 - inc_base);
    checkOutput("wrap_count", wrap_cnt, 4'd1);
    checkOutput("drain4", sb4.size(), 0);
    checkOutput("drain0", sb0.size(), 0);

    // Now at 01; step to 11 and pull reset while the increment strobe is high.
    applyStimulus(1'b1, 1'b1, 0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = increment4;
    end
    checkOutput("midrst_seen", seen, 1'b1);
    #2 reset_n = 1'b0;
    #1 checkOutput("midrst_drop", increment4, 1'b0);
    checkOutput("midrst_dir", dir4, 1'b1);
    sb4.delete();
    sb0.delete();
    exp_dir4 = 1'b1;
    exp_dir0 = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 10, 1'b1);
    checkOutput("final_drain4", sb4.size(), 0);
    checkOutput("final_drain0", sb0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
